// File: rtl/divider_pkg.sv
// Shared widths, step count and FSM encoding for the 32/16 sequential divider.
// Pure declarations; no latency or flow-control behaviour of its own.
package divider_pkg;

   localparam int unsigned DIVIDEND_W = 32;
   localparam int unsigned DIVISOR_W  = 16;
   localparam int unsigned N_STEPS    = 32;
   localparam int unsigned CNT_W      = 6;

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N_STEPS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on a 17-bit partial remainder.
// Zero latency; no flow control.
module div_step
   import divider_pkg::*;
(
   input  logic [DIVISOR_W:0]   rem_i,
   input  logic                 bit_i,
   input  logic [DIVISOR_W-1:0] divisor_i,
   output logic [DIVISOR_W:0]   rem_o,
   output logic                 q_bit_o
);

   logic [DIVISOR_W:0] shifted;
   logic [DIVISOR_W:0] diff;

   // A set top bit means the shifted value exceeds any 16-bit divisor; the
   // modular 17-bit difference is still exact because the result is < divisor.
   assign shifted = {rem_i[DIVISOR_W-1:0], bit_i};
   assign diff    = shifted - {1'b0, divisor_i};
   assign q_bit_o = rem_i[DIVISOR_W] | (shifted >= {1'b0, divisor_i});
   assign rem_o   = q_bit_o ? diff : shifted;

endmodule

// File: rtl/divider_32by16_seq.sv
// Unsigned 32/16 restoring divider: 33 cycles accept-to-done (1 for divisor 0).
// start is sampled only in IDLE; requests while busy are dropped, never queued.
module divider_32by16_seq
   import divider_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  busy,
   output logic                  done,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic [DIVISOR_W-1:0]  remainder,
   output logic                  div_by_zero,
   output logic                  q_fits16
);

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
   logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
   logic [DIVISOR_W:0]    prem_q, prem_d;
   logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
   logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
   logic                  dbz_q, dbz_d;
   logic                  fits_q, fits_d;

   logic [DIVISOR_W:0]    step_rem;
   logic                  step_qbit;
   logic [DIVIDEND_W-1:0] quot_next;

   div_step u_step (
      .rem_i     (prem_q),
      .bit_i     (dvd_q[DIVIDEND_W-1]),
      .divisor_i (dvs_q),
      .rem_o     (step_rem),
      .q_bit_o   (step_qbit)
   );

   // Dividend bits leave at the top while quotient bits enter at the bottom,
   // so after the last step the operand register holds the full quotient.
   assign quot_next = {dvd_q[DIVIDEND_W-2:0], step_qbit};

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      dvd_d       = dvd_q;
      dvs_d       = dvs_q;
      prem_d      = prem_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;
      fits_d      = fits_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (divisor != '0) begin
                  dvd_d   = dividend;
                  dvs_d   = divisor;
                  prem_d  = '0;
                  cnt_d   = '0;
                  state_d = CALC;
               end else begin
                  quotient_d  = '1;
                  remainder_d = dividend[DIVISOR_W-1:0];
                  dbz_d       = 1'b1;
                  fits_d      = 1'b0;
                  state_d     = DONE;
               end
            end
         end
         CALC: begin
            prem_d = step_rem;
            dvd_d  = quot_next;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LAST_STEP) begin
               quotient_d  = quot_next;
               remainder_d = step_rem[DIVISOR_W-1:0];
               dbz_d       = 1'b0;
               fits_d      = (quot_next[DIVIDEND_W-1:DIVISOR_W] == '0);
               state_d     = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         dvd_q       <= '0;
         dvs_q       <= '0;
         prem_q      <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
         fits_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         dvd_q       <= dvd_d;
         dvs_q       <= dvs_d;
         prem_q      <= prem_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
         fits_q      <= fits_d;
      end
   end

   assign busy        = (state_q != IDLE);
   assign done        = (state_q == DONE);
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;
   assign q_fits16    = fits_q;

endmodule

// File: tb/tb_divider_32by16_seq.sv
// Bench for divider_32by16_seq: directed vectors, random operands against an
// arithmetic reference, busy-time start filtering, reset abort and back-to-back.
module tb_divider_32by16_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] dividend;
   logic [15:0] divisor;
   logic        busy, done;
   logic [31:0] quotient;
   logic [15:0] remainder;
   logic        div_by_zero, q_fits16;

   int checks   = 0;
   int failures = 0;
   int done_cnt = 0;

   always #5 clk = ~clk;

   always @(negedge clk) if (done === 1'b1) done_cnt++;

   divider_32by16_seq dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .q_fits16    (q_fits16)
   );

   // Reference: plain integer division, with the defined divide-by-zero result.
   function automatic void ref_div(input logic [31:0] a, input logic [15:0] b,
                                   output logic [31:0] q, output logic [15:0] r,
                                   output logic dbz, output logic fits, output int lat);
      if (b == 16'd0) begin
         q = 32'hFFFF_FFFF; r = a[15:0]; dbz = 1'b1; fits = 1'b0; lat = 1;
      end else begin
         q = a / {16'd0, b};
         r = 16'(a % {16'd0, b});
         dbz = 1'b0; fits = (q < 32'h0001_0000); lat = 33;
      end
   endfunction

   // Caller sits just after a rising edge in an IDLE cycle; returns in cycle 1.
   task automatic launch(input logic [31:0] a, input logic [15:0] b);
      start = 1'b1; dividend = a; divisor = b;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 1;
      while (done !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset();
      logic [31:0] eq; logic [15:0] er; logic ed, ef; int el, lat;
      rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
      #12;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || quotient !== 32'd0 || remainder !== 16'd0 ||
          div_by_zero !== 1'b0 || q_fits16 !== 1'b1) begin
         failures++;
         $display("FAIL reset_values: busy=%b done=%b q=%h r=%h dbz=%b fits=%b, need 0 0 0 0 0 1",
                  busy, done, quotient, remainder, div_by_zero, q_fits16);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      launch(32'hDEAD_BEEF, 16'h1357);
      ref_div(32'hDEAD_BEEF, 16'h1357, eq, er, ed, ef, el);
      wait_done(lat);
      checks++;
      if (lat !== el || quotient !== eq || remainder !== er) begin
         failures++;
         $display("FAIL first_after_reset: lat=%0d q=%h r=%h, need lat=%0d q=%h r=%h",
                  lat, quotient, remainder, el, eq, er);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_vectors();
      logic [31:0] va [5] = '{32'h0000_000C, 32'hFFFE_0001, 32'h0000_0064, 32'h1234_5678, 32'h0000_1234};
      logic [15:0] vb [5] = '{16'h0003, 16'hFFFF, 16'h0007, 16'h0001, 16'h0000};
      logic [31:0] vq [5] = '{32'h4, 32'h0000_FFFF, 32'hE, 32'h1234_5678, 32'hFFFF_FFFF};
      logic [15:0] vr [5] = '{16'h0, 16'h0, 16'h2, 16'h0, 16'h1234};
      logic        vf [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic        vz [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      int          vl [5] = '{33, 33, 33, 33, 1};
      int lat;
      for (int i = 0; i < 5; i++) begin
         launch(va[i], vb[i]);
         wait_done(lat);
         checks++;
         if (lat !== vl[i] || quotient !== vq[i] || remainder !== vr[i] ||
             q_fits16 !== vf[i] || div_by_zero !== vz[i]) begin
            failures++;
            $display("FAIL vector%0d: lat=%0d q=%h r=%h fits=%b dbz=%b, need lat=%0d q=%h r=%h fits=%b dbz=%b",
                     i, lat, quotient, remainder, q_fits16, div_by_zero,
                     vl[i], vq[i], vr[i], vf[i], vz[i]);
         end
         @(posedge clk); #1;
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL vector%0d_pulse: done=%b busy=%b, need 0 0", i, done, busy);
         end
      end
   endtask

   task automatic test_ignore_busy_start();
      logic [31:0] eq; logic [15:0] er; logic ed, ef; int el, lat;
      ref_div(32'h8765_4321, 16'h00F1, eq, er, ed, ef, el);
      launch(32'h8765_4321, 16'h00F1);
      for (int i = 1; i < 10; i++) begin @(posedge clk); #1; end
      for (int i = 0; i < 3; i++) begin
         start = 1'b1; dividend = $urandom; divisor = 16'($urandom);
         @(posedge clk); #1;
      end
      start = 1'b0;
      wait_done(lat);
      lat = lat + 12;
      checks++;
      if (lat !== el || quotient !== eq || remainder !== er || q_fits16 !== ef) begin
         failures++;
         $display("FAIL ignore_busy_start: lat=%0d q=%h r=%h fits=%b, need lat=%0d q=%h r=%h fits=%b",
                  lat, quotient, remainder, q_fits16, el, eq, er, ef);
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL no_queued_op: busy=%b, need 0", busy);
      end
   endtask

   task automatic test_random();
      logic [31:0] a, eq; logic [15:0] b, er; logic ed, ef; int el, lat;
      for (int n = 0; n < 40; n++) begin
         a = $urandom;
         case ($urandom_range(0, 7))
            0:       b = 16'd0;
            1, 2:    b = 16'($urandom_range(1, 15));
            3, 4:    b = 16'h8000 | 16'($urandom);
            default: b = 16'($urandom_range(1, 65535));
         endcase
         if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(8, 28);
         ref_div(a, b, eq, er, ed, ef, el);
         launch(a, b);
         if (b != 16'd0) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
               failures++;
               $display("FAIL rand%0d_busy: busy=%b done=%b, need 1 0", n, busy, done);
            end
         end
         wait_done(lat);
         checks++;
         if (lat !== el || quotient !== eq || remainder !== er ||
             div_by_zero !== ed || q_fits16 !== ef) begin
            failures++;
            $display("FAIL rand%0d %h/%h: lat=%0d q=%h r=%h dbz=%b fits=%b, need lat=%0d q=%h r=%h dbz=%b fits=%b",
                     n, a, b, lat, quotient, remainder, div_by_zero, q_fits16, el, eq, er, ed, ef);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] q1, q2; logic [15:0] r1, r2; logic d1, f1, d2, f2; int l1, l2, lat, dc0;
      ref_div(32'h0BAD_F00D, 16'h0123, q1, r1, d1, f1, l1);
      ref_div(32'h0000_FFFF, 16'h8001, q2, r2, d2, f2, l2);
      dc0 = done_cnt;
      launch(32'h0BAD_F00D, 16'h0123);
      wait_done(lat);
      checks++;
      if (lat !== l1 || quotient !== q1 || remainder !== r1) begin
         failures++;
         $display("FAIL b2b_first: lat=%0d q=%h r=%h, need lat=%0d q=%h r=%h", lat, quotient, remainder, l1, q1, r1);
      end
      start = 1'b1; dividend = 32'h0000_FFFF; divisor = 16'h8001;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || quotient !== q1) begin
         failures++;
         $display("FAIL b2b_idle: busy=%b done=%b q=%h, need 0 0 %h", busy, done, quotient, q1);
      end
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || quotient !== q1 || remainder !== r1) begin
         failures++;
         $display("FAIL b2b_hold: busy=%b q=%h r=%h, need 1 %h %h", busy, quotient, remainder, q1, r1);
      end
      wait_done(lat);
      checks++;
      if (lat !== l2 || quotient !== q2 || remainder !== r2 || q_fits16 !== f2) begin
         failures++;
         $display("FAIL b2b_second: lat=%0d q=%h r=%h fits=%b, need lat=%0d q=%h r=%h fits=%b",
                  lat, quotient, remainder, q_fits16, l2, q2, r2, f2);
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if (done_cnt - dc0 !== 2) begin
         failures++;
         $display("FAIL b2b_pulses: got %0d done pulses, need 2", done_cnt - dc0);
      end
   endtask

   task automatic test_abort_reset();
      logic [31:0] eq; logic [15:0] er; logic ed, ef; int el, lat, dc0;
      launch(32'hCAFE_1234, 16'h0055);
      for (int i = 1; i < 10; i++) begin @(posedge clk); #1; end
      start = 1'b1; dividend = 32'h0000_0001; divisor = 16'h0000;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 11; i < 20; i++) begin @(posedge clk); #1; end
      dc0 = done_cnt;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || quotient !== 32'd0 || remainder !== 16'd0 ||
          div_by_zero !== 1'b0 || q_fits16 !== 1'b1) begin
         failures++;
         $display("FAIL abort_reset_values: busy=%b done=%b q=%h r=%h dbz=%b fits=%b, need 0 0 0 0 0 1",
                  busy, done, quotient, remainder, div_by_zero, q_fits16);
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin @(posedge clk); #1; end
      checks++;
      if (done_cnt !== dc0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL abort_no_done: pulses=%0d busy=%b, need 0 0", done_cnt - dc0, busy);
      end
      ref_div(32'h7FFF_FFFF, 16'h8000, eq, er, ed, ef, el);
      launch(32'h7FFF_FFFF, 16'h8000);
      wait_done(lat);
      checks++;
      if (lat !== el || quotient !== eq || remainder !== er || q_fits16 !== ef) begin
         failures++;
         $display("FAIL after_abort: lat=%0d q=%h r=%h fits=%b, need lat=%0d q=%h r=%h fits=%b",
                  lat, quotient, remainder, q_fits16, el, eq, er, ef);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_ignore_busy_start();
      test_random();
      test_back_to_back();
      test_abort_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
